sat_expr_pipe: RTL and testbench

SAT_EXPR_PIPE -- requirements
Module: sat_expr_pipe

---
 rtl/sat_expr_pkg.sv | 21 ++
 rtl/sat_clamp.sv | 30 +++
 rtl/sat_expr_pipe.sv | 125 ++++++++++++
 tb/tb_sat_expr_pipe.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/sat_expr_pkg.sv
// Shared constants and width helpers for the sat_expr_pipe datapath.
package sat_expr_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;
  localparam int   STAGES    = 3;

  // Full-precision widths of the intermediate terms for a w-bit operand pair
  function automatic int sum_w(input int w);
    return w + 1;
  endfunction

  function automatic int prod_w(input int w);
    return 2 * w + 2;
  endfunction

  function automatic int tot_w(input int w);
    return 2 * w + 3;
  endfunction

endpackage

// File: rtl/sat_clamp.sv
// Signed range check of an IN_W-bit value against OUT_W bits, with optional clamp.
module sat_clamp
  import sat_expr_pkg::*;
#(
  parameter int IN_W  = 19,
  parameter int OUT_W = 8
) (
  input  logic [IN_W-1:0]  i_val,
  input  logic             i_sat,
  output logic [OUT_W-1:0] out,
  output logic             ovf
);

  logic [IN_W-OUT_W:0] w_hi;
  logic [OUT_W-1:0]    w_max;
  logic [OUT_W-1:0]    w_min;

  // Value fits iff every bit from the target sign bit upward is identical
  assign w_hi  = i_val[IN_W-1:OUT_W-1];
  assign ovf   = !((&w_hi) || !(|w_hi));
  assign w_max = {1'b0, {(OUT_W-1){1'b1}}};
  assign w_min = {1'b1, {(OUT_W-1){1'b0}}};

  always_comb begin
    out = i_val[OUT_W-1:0];
    if (i_sat == MODE_SAT && ovf)
      out = i_val[IN_W-1] ? w_min : w_max;
  end

endmodule

// File: rtl/sat_expr_pipe.sv
// 3-stage pipeline computing (a+b) + (a-b)*b + b with saturate/wrap output.
// Overflow event counter is built only when SAT_EXPR_PIPE_STATS_EN is defined.
module sat_expr_pipe
  import sat_expr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sat_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_ovf,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] ovf_count
);

  localparam int SW = sum_w(WIDTH);
  localparam int PW = prod_w(WIDTH);
  localparam int TW = tot_w(WIDTH);

  logic [STAGES:1] r_vld_pipe;
  logic            w_adv;

  logic [SW-1:0]    r_s1_sum, r_s1_dif;
  logic [WIDTH-1:0] r_s1_b;
  logic             r_s1_mode;

  logic [PW-1:0]    r_s2_prod;
  logic [SW:0]      r_s2_sb;
  logic             r_s2_mode;

  logic [WIDTH-1:0] r_out;
  logic             r_ovf;

  logic [SW-1:0]    w_a_x, w_b_x, w_sum, w_dif;
  logic [PW-1:0]    w_dif_x, w_b_px, w_prod;
  logic [SW:0]      w_sb;
  logic [TW-1:0]    w_tot;
  logic [WIDTH-1:0] w_out;
  logic             w_ovf;

  // Whole pipe moves in lockstep; a stalled output freezes every stage
  assign w_adv    = !r_vld_pipe[STAGES] || out_ready;
  assign in_ready = w_adv;

  assign w_a_x = {a[WIDTH-1], a};
  assign w_b_x = {b[WIDTH-1], b};
  assign w_sum = w_a_x + w_b_x;
  assign w_dif = w_a_x - w_b_x;

  // Sign-extended to the product width; the low PW bits are the exact product
  assign w_dif_x = {{(PW-SW){r_s1_dif[SW-1]}}, r_s1_dif};
  assign w_b_px  = {{(PW-WIDTH){r_s1_b[WIDTH-1]}}, r_s1_b};
  assign w_prod  = w_dif_x * w_b_px;
  assign w_sb    = {r_s1_sum[SW-1], r_s1_sum} + {{2{r_s1_b[WIDTH-1]}}, r_s1_b};

  assign w_tot = {r_s2_prod[PW-1], r_s2_prod} + {{(TW-SW-1){r_s2_sb[SW]}}, r_s2_sb};

  sat_clamp #(
    .IN_W  (TW),
    .OUT_W (WIDTH)
  ) u_clamp (
    .i_val (w_tot),
    .i_sat (r_s2_mode),
    .out   (w_out),
    .ovf   (w_ovf)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld_pipe <= '0;
      r_s1_sum   <= '0;
      r_s1_dif   <= '0;
      r_s1_b     <= '0;
      r_s1_mode  <= MODE_WRAP;
      r_s2_prod  <= '0;
      r_s2_sb    <= '0;
      r_s2_mode  <= MODE_WRAP;
      r_out      <= '0;
      r_ovf      <= 1'b0;
    end else if (w_adv) begin
      r_vld_pipe <= {r_vld_pipe[STAGES-1:1], in_valid};
      r_s1_sum   <= w_sum;
      r_s1_dif   <= w_dif;
      r_s1_b     <= b;
      r_s1_mode  <= sat_mode;
      r_s2_prod  <= w_prod;
      r_s2_sb    <= w_sb;
      r_s2_mode  <= r_s1_mode;
      r_out      <= w_out;
      r_ovf      <= w_ovf;
    end
  end

  assign out_valid = r_vld_pipe[STAGES];
  assign out       = r_out;
  assign out_ovf   = r_ovf;

`ifdef SAT_EXPR_PIPE_STATS_EN
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_cnt <= '0;
    else if (cnt_clr)
      r_cnt <= '0;
    else if (r_vld_pipe[STAGES] && out_ready && r_ovf && !(&r_cnt))
      r_cnt <= r_cnt + CNT_W'(1);
  end

  assign ovf_count = r_cnt;
`else
  logic w_unused_clr;
  assign w_unused_clr = cnt_clr;
  assign ovf_count    = '0;
`endif

endmodule

// File: tb/tb_sat_expr_pipe.sv
// Directed self-checking bench for sat_expr_pipe (WIDTH=8, CNT_W=2).
module tb_sat_expr_pipe;

`ifdef SAT_EXPR_PIPE_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid, in_ready;
  logic [7:0] a, b;
  logic       sat_mode;
  logic       out_valid, out_ready;
  logic [7:0] out;
  logic       out_ovf;
  logic       cnt_clr;
  logic [1:0] ovf_count;

  int n_checks = 0;
  int n_err    = 0;
  int exp_cnt  = 0;

  always #5 clk = ~clk;

  sat_expr_pipe #(.WIDTH(8), .CNT_W(2)) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sat_mode  (sat_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .out_ovf   (out_ovf),
    .cnt_clr   (cnt_clr),
    .ovf_count (ovf_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Counter model: clear wins, saturates at 3 for CNT_W=2
  task automatic bump(input logic ovf, input logic clr);
    if (clr) exp_cnt = 0;
    else if (ovf && exp_cnt < 3) exp_cnt++;
  endtask

  task automatic chk_cnt(input string tag);
    chk(tag, 32'(ovf_count), STATS_EN ? exp_cnt : 0);
  endtask

  task automatic run_one(input int av, input int bv, input logic m,
                         input int eo, input logic eovf, input logic clr);
    @(negedge clk);
    a = av[7:0]; b = bv[7:0]; sat_mode = m; in_valid = 1'b1;
    #1 chk("accept_ready", 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("lat_c1_valid", 32'(out_valid), 0);
    @(negedge clk);
    #1 chk("lat_c2_valid", 32'(out_valid), 0);
    @(negedge clk);
    cnt_clr = clr;
    #1;
    chk("lat_c3_valid", 32'(out_valid), 1);
    chk("out", 32'(out), eo & 255);
    chk("out_ovf", 32'(out_ovf), 32'(eovf));
    @(negedge clk);
    cnt_clr = 1'b0;
    bump(eovf, clr);
    #1;
    chk_cnt("ovf_count");
    chk("drained", 32'(out_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int tx, rx, cyc;
    reset_n = 1'b1; in_valid = 1'b0; a = '0; b = '0; sat_mode = 1'b0;
    out_ready = 1'b1; cnt_clr = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out", 32'(out), 0);
    chk("rst_out_ovf", 32'(out_ovf), 0);
    chk("rst_ovf_count", 32'(ovf_count), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1 chk("post_rst_ready", 32'(in_ready), 1);

    // Main function, both modes, range edges
    run_one(   3,   2, 1'b1,    9, 1'b0, 1'b0);
    run_one( 100, 100, 1'b1,  127, 1'b1, 1'b0);
    run_one( 100, 100, 1'b0,   44, 1'b1, 1'b0);
    run_one(-128, 127, 1'b1, -128, 1'b1, 1'b0);
    run_one(-128, 127, 1'b0,   -3, 1'b1, 1'b1);
    run_one(  -5,   3, 1'b0,  -23, 1'b0, 1'b0);
    run_one( 127,   0, 1'b1,  127, 1'b0, 1'b0);
    run_one(-128,   0, 1'b0, -128, 1'b0, 1'b0);
    run_one(-128,   1, 1'b1, -128, 1'b1, 1'b0);
    run_one(-128,   1, 1'b0,    1, 1'b1, 1'b0);
    run_one(  64,   1, 1'b1,  127, 1'b1, 1'b0);
    run_one(  64,   1, 1'b0, -127, 1'b1, 1'b0);
    run_one( 100, 100, 1'b1,  127, 1'b1, 1'b0);

    // Back-to-back stream with output stalled: results are 2a+1 for b=1
    tx = 0; rx = 0; cyc = 0;
    out_ready = 1'b0;
    while (rx < 6 && cyc < 40) begin
      @(negedge clk);
      out_ready = (cyc >= 8);
      in_valid  = (tx < 6);
      a = 8'(tx + 1); b = 8'd1; sat_mode = 1'b0;
      #1;
      if (cyc >= 3 && cyc <= 7) begin
        chk("stall_in_ready", 32'(in_ready), 0);
        chk("stall_out_hold", 32'(out), 3);
      end
      if (out_valid && out_ready) begin
        chk("stream_out", 32'(out), 2 * (rx + 1) + 1);
        rx++;
      end
      if (in_valid && in_ready) tx++;
      cyc++;
    end
    in_valid = 1'b0;
    chk("stream_count", rx, 6);
    chk_cnt("stream_ovf_count");

    // Reset with three overflow results in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = 8'd100; b = 8'd100; sat_mode = 1'b1; in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("pre_rst_valid", 32'(out_valid), 1);
    reset_n = 1'b0;
    exp_cnt = 0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_out", 32'(out), 0);
    chk("midrst_out_ovf", 32'(out_ovf), 0);
    chk_cnt("midrst_ovf_count");
    @(negedge clk);
    reset_n = 1'b1; out_ready = 1'b1;
    #1 chk("rel_in_ready", 32'(in_ready), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1 chk("no_stale", 32'(out_valid), 0);
    end
    chk_cnt("post_rel_count");
    run_one(3, 2, 1'b1, 9, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
